config_chain_loader: RTL and testbench
======================================

Name: config_chain_loader

Overview:
- Serial programming controller that drives a configuration scan chain built from scan flip-flops: shift-enable, scan input and configure-enable, with the chain's D paths holding Q when not shifting.
- Accepts the bitstream as WORD_W-bit words over a valid/ready stream and shifts exactly CHAIN_LEN bits into the chain.
- Simultaneously captures the bits leaving the chain tail, returning the old contents as a readback word stream.
- Asserts chain_cfge once the load completes, releasing the configured outputs.

Parameters:
CHAIN_LEN, 64, number of flops in the chain (>= 1)
WORD_W, 8, bitstream/readback word width (>= 1)
CNT_W, 16, bit-counter width; must satisfy 2^CNT_W > CHAIN_LEN

Ports:
CK  input  1  clock; chain flops share it
RST  input  1  reset, asynchronous, active-high
start  input  1  begin a load; sampled only in IDLE
s_valid  input  1  bitstream word valid
s_ready  output  1  bitstream word accepted when s_valid && s_ready
s_data  input  WORD_W  bitstream word, LSB shifted first
m_valid  output  1  readback word valid
m_ready  input  1  readback word consumed when m_valid && m_ready
m_data  output  WORD_W  readback word, LSB = first bit out of chain
chain_si  output  1  scan data to chain head
chain_se  output  1  shift strobe; chain shifts on the CK edge where it is 1
chain_so  input  1  chain tail Q
chain_cfge  output  1  configure enable to chain
busy  output  1  high in LOAD and FINISH
done  output  1  one-cycle pulse on load completion

Behaviour:
- Reset values: s_ready=0, m_valid=0, m_data=0, chain_si=0, chain_se=0, chain_cfge=0, busy=0, done=0. State=IDLE; all counters and buffers cleared.
- Reset mid-load: immediate abort. Chain contents are undefined; chain_cfge stays 0 until the next complete load.
- State IDLE:
  - start=1 -> LOAD next cycle.
  - bits_left=CHAIN_LEN, words_left=ceil(CHAIN_LEN/WORD_W).
  - chain_cfge cleared on the same edge.
  - chain_cfge otherwise holds: 1 after a completed load, 0 after reset.
- State LOAD:
  - Word register holds the current word plus bit_cnt, the number of unused bits.
  - Shift condition: bit_cnt>0 && !(m_valid && !m_ready).
  - On a shift cycle:
    - chain_se=1 and chain_si = current word LSB (combinational from registers).
    - chain_so is sampled into the readback packer.
    - Word shifts right; bit_cnt-1, bits_left-1.
  - On a non-shift cycle: chain_se=0 and chain_si=0.
  - s_ready = LOAD && words_left>0 && (bit_cnt==0 || (shift && bit_cnt==1)). This gives one bit per CK with no inter-word bubble when the source keeps up.
  - On a word accept: bit_cnt=WORD_W and words_left-1.
- Last-word truncation:
  - When bits_left reaches 0, residual bits of the last word are discarded and bit_cnt is forced to 0.
  - Surplus input words are never requested.
- Readback packer:
  - Captured bits fill from bit 0 upward.
  - m_valid rises the cycle after WORD_W bits have been captured, or after the final bit (partial word, upper bits 0).
  - m_valid and m_data hold until m_ready.
  - A handshake with no new completed word drops m_valid the next cycle.
  - Back-to-back completion and consumption on the same edge is allowed.
- LOAD -> FINISH on the edge of the last shift. FINISH waits until the final readback word is consumed.
- FINISH -> IDLE:
  - chain_cfge=1 and done=1 (one cycle) in the IDLE cycle entered.
  - Latency: done is asserted exactly 1 cycle after the last shift edge when m_ready=1.
- start while busy is ignored. s_valid outside LOAD is ignored; s_ready=0 there.
- Bit placement: first bit shifted ends at chain position CHAIN_LEN-1 (tail); last bit shifted at position 0 (head).

Test Plan:
- Reset: CHAIN_LEN=10, WORD_W=4; RST pulse mid-cycle, asynchronous -> all outputs 0 immediately; start ignored while RST=1.
- Full load, fast source: CHAIN_LEN=10, WORD_W=4, words 0xA, 0x5, 0xF, m_ready=1 -> exactly 10 chain_se cycles, contiguous.
  - chain_si sequence 0,1,0,1,1,0,1,0,1,1; bits 2-3 of 0xF dropped.
  - done/chain_cfge rise 1 cycle after the 10th shift.
  - s_ready accepts exactly 3 words.
- Readback: chain model preloaded with 0x3A5 (tail bit first = bit 0) -> m_data words 0x5, 0xA, 0x3 (last partial, upper bits 0).
- Backpressure: hold m_ready=0 after the first readback word -> chain_se=0 after the 4th shift until m_ready=1; no bits lost or duplicated.
- Source starvation: s_valid low 5 cycles between words -> chain_se=0 during the gap; final chain contents identical to the fast case.
- Abort/restart: RST at shift 6 -> chain_cfge=0; new start plus full load -> done after 10 shifts; start pulses during LOAD ignored.

Source files
------------

// File: rtl/config_chain_loader_if.sv
// config_chain_loader_if: bitstream in, readback out, and the scan-chain pins.
interface config_chain_loader_if #(parameter int WORD_W = 8);
  logic start, s_valid, s_ready, m_valid, m_ready;
  logic chain_si, chain_se, chain_so, chain_cfge, busy, done;
  logic [WORD_W-1:0] s_data, m_data;
  modport master(output start, s_valid, s_data, m_ready, chain_so,
                 input s_ready, m_valid, m_data, chain_si, chain_se, chain_cfge, busy, done);
  modport slave(input start, s_valid, s_data, m_ready, chain_so,
                output s_ready, m_valid, m_data, chain_si, chain_se, chain_cfge, busy, done);
endinterface

// File: rtl/config_chain_loader.sv
// config_chain_loader: shifts CHAIN_LEN bitstream bits into a scan chain while
// packing the bits falling off its tail into readback words.
module config_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W = 8,
  parameter int CNT_W = 16
) (
  input logic CK,
  input logic RST,
  config_chain_loader_if.slave bus
);
  localparam int BW = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] NWORDS = CNT_W'((CHAIN_LEN + WORD_W - 1) / WORD_W);
  typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] bits_left_q, bits_left_d, words_left_q, words_left_d;
  logic [WORD_W-1:0] word_q, word_d, pack_q, pack_d, m_data_q, m_data_d, packed_w;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d, pack_cnt_q, pack_cnt_d;
  logic m_valid_q, m_valid_d, cfge_q, cfge_d, done_q, done_d;
  logic shift, last, accept, emit, m_hs;
  // a pending unconsumed readback word stalls the chain so no tail bit is lost
  assign shift = state_q == LOAD && bit_cnt_q != '0 && !(m_valid_q && !bus.m_ready);
  assign last = shift && bits_left_q == CNT_W'(1);
  assign bus.s_ready = state_q == LOAD && words_left_q != '0 &&
                       (bit_cnt_q == '0 || (shift && bit_cnt_q == BW'(1)));
  assign accept = bus.s_valid && bus.s_ready;
  assign m_hs = m_valid_q && bus.m_ready;
  assign packed_w = pack_q | (WORD_W'(bus.chain_so) << pack_cnt_q);
  assign emit = shift && (pack_cnt_q == BW'(WORD_W - 1) || last);
  assign bus.chain_se = shift;
  assign bus.chain_si = shift && word_q[0];
  assign bus.m_valid = m_valid_q;
  assign bus.m_data = m_data_q;
  assign bus.chain_cfge = cfge_q;
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  always_comb begin
    state_d = state_q;
    bits_left_d = bits_left_q;
    words_left_d = words_left_q;
    word_d = word_q;
    bit_cnt_d = bit_cnt_q;
    pack_d = pack_q;
    pack_cnt_d = pack_cnt_q;
    m_valid_d = emit ? 1'b1 : m_hs ? 1'b0 : m_valid_q;
    m_data_d = emit ? packed_w : m_data_q;
    cfge_d = cfge_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = LOAD;
        bits_left_d = CNT_W'(CHAIN_LEN);
        words_left_d = NWORDS;
        bit_cnt_d = '0;
        pack_d = '0;
        pack_cnt_d = '0;
        cfge_d = 1'b0;
      end
      LOAD: begin
        if (shift) begin
          word_d = word_q >> 1;
          bit_cnt_d = last ? '0 : bit_cnt_q - BW'(1);
          bits_left_d = bits_left_q - CNT_W'(1);
          pack_d = emit ? '0 : packed_w;
          pack_cnt_d = emit ? '0 : pack_cnt_q + BW'(1);
          state_d = last ? FINISH : LOAD;
        end
        if (accept) begin
          word_d = bus.s_data;
          bit_cnt_d = BW'(WORD_W);
          words_left_d = words_left_q - CNT_W'(1);
        end
      end
      FINISH: if (!m_valid_q || bus.m_ready) begin
        state_d = IDLE;
        cfge_d = 1'b1;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      bits_left_q <= '0;
      words_left_q <= '0;
      word_q <= '0;
      bit_cnt_q <= '0;
      pack_q <= '0;
      pack_cnt_q <= '0;
      m_valid_q <= 1'b0;
      m_data_q <= '0;
      cfge_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bits_left_q <= bits_left_d;
      words_left_q <= words_left_d;
      word_q <= word_d;
      bit_cnt_q <= bit_cnt_d;
      pack_q <= pack_d;
      pack_cnt_q <= pack_cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q <= m_data_d;
      cfge_q <= cfge_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_config_chain_loader.sv
// tb_config_chain_loader: directed loads against a bench-side chain and a
// bit-queue model of what must go in and what must come back.
module tb_config_chain_loader;
  localparam int L = 10;
  localparam int W = 4;
  localparam int NW = 3;
  logic CK = 0;
  logic RST;
  always #5 CK = ~CK;
  config_chain_loader_if #(.WORD_W(W)) bus();
  config_chain_loader #(.CHAIN_LEN(L), .WORD_W(W), .CNT_W(16)) dut (.CK(CK), .RST(RST), .bus(bus.slave));
  logic [L-1:0] chain, pre_v, exp_final;
  logic pre_en, src_stop;
  logic [W-1:0] words [NW] = '{4'hA, 4'h5, 4'hF};
  bit exp_si [$];
  logic [W-1:0] exp_rb [$], got_rb [$];
  int pass_cnt = 0, tot_cnt = 0;
  int cyc = 0, se_cnt = 0, acc_cnt = 0, done_cnt = 0, first_se = 0, last_se = 0, done_cyc = 0;
  always @(posedge CK) cyc <= cyc + 1;
  always @(posedge CK) chain <= pre_en ? pre_v : bus.chain_se ? {chain[L-2:0], bus.chain_si} : chain;
  assign bus.chain_so = chain[L-1];
  wire [10:0] outs = {bus.s_ready, bus.m_valid, bus.m_data, bus.chain_si, bus.chain_se,
                      bus.chain_cfge, bus.busy, bus.done};
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask
  initial forever begin
    @(negedge CK);
    if (!RST) begin
      if (bus.chain_se) begin
        se_cnt++;
        if (se_cnt == 1) first_se = cyc;
        last_se = cyc;
        if (exp_si.size() == 0) check("se_count", se_cnt, L);
        else check("chain_si", bus.chain_si, exp_si.pop_front());
      end
      if (bus.m_valid && !bus.m_ready) check("stall_se", bus.chain_se, 0);
      if (bus.m_valid && bus.m_ready) begin
        got_rb.push_back(bus.m_data);
        if (exp_rb.size() == 0) check("rb_count", got_rb.size(), NW);
        else check("m_data", bus.m_data, exp_rb.pop_front());
      end
      if (bus.s_valid && bus.s_ready) acc_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end
  task automatic source(input int gap);
    int t;
    for (int k = 0; k < NW; k++) begin
      bus.s_data = words[k];
      bus.s_valid = 1;
      t = 0;
      do begin
        @(negedge CK);
        t++;
      end while (!bus.s_ready && !src_stop && t < 200);
      if (src_stop) begin
        bus.s_valid = 0;
        return;
      end
      if (!bus.s_ready) begin
        check("s_ready_timeout", t, 0);
        bus.s_valid = 0;
        return;
      end
      @(posedge CK);
      #1 bus.s_valid = 0;
      repeat (gap) @(posedge CK);
      #1;
    end
    bus.s_data = '1;
    bus.s_valid = 1;
  endtask
  task automatic load(input int gap, input bit hold, input bit pulses, input int abort_at, input logic [L-1:0] pre);
    int t, d0;
    logic [W-1:0] v;
    src_stop = 0;
    for (int i = 0; i < L; i++) pre_v[L-1-i] = pre[i];
    pre_en = 1;
    @(posedge CK);
    #1 pre_en = 0;
    exp_si.delete();
    exp_rb.delete();
    got_rb.delete();
    for (int i = 0; i < L; i++) begin
      exp_si.push_back(words[i/W][i%W]);
      exp_final[L-1-i] = words[i/W][i%W];
    end
    for (int k = 0; k < NW; k++) begin
      v = '0;
      for (int j = 0; j < W; j++) if (k*W + j < L) v[j] = pre[k*W + j];
      exp_rb.push_back(v);
    end
    se_cnt = 0;
    acc_cnt = 0;
    d0 = done_cnt;
    bus.m_ready = !hold;
    bus.start = 1;
    @(posedge CK);
    #1 bus.start = 0;
    check("cfge_clr", bus.chain_cfge, 0);
    check("busy_load", bus.busy, 1);
    fork source(gap); join_none
    if (abort_at > 0) begin
      t = 0;
      while (se_cnt < abort_at && t < 200) begin
        @(negedge CK);
        #1 t++;
      end
      #2 RST = 1;
      #1 check("abort_outs", outs, 0);
      src_stop = 1;
      bus.m_ready = 1;
      repeat (2) @(posedge CK);
      #1 RST = 0;
      repeat (2) @(posedge CK);
      #1 check("abort_cfge", bus.chain_cfge, 0);
      check("abort_idle", bus.busy, 0);
      return;
    end
    if (pulses) begin
      repeat (3) @(posedge CK);
      #1 bus.start = 1;
      @(posedge CK);
      #1 bus.start = 0;
    end
    if (hold) begin
      t = 0;
      while (!bus.m_valid && t < 100) begin
        @(negedge CK);
        #1 t++;
      end
      repeat (6) @(negedge CK);
      #1 check("bp_se_cnt", se_cnt, 4);
      @(posedge CK);
      #1 bus.m_ready = 1;
    end
    t = 0;
    while (done_cnt == d0 && t < 300) begin
      @(negedge CK);
      #1 t++;
    end
    check("done_seen", done_cnt - d0, 1);
    check("done_cfge", bus.chain_cfge, 1);
    check("done_lat", done_cyc - last_se, 2);
    check("shift_cnt", se_cnt, L);
    check("accepts", acc_cnt, NW);
    check("final_chain", chain, exp_final);
    check("rb_words", got_rb.size(), NW);
    if (gap == 0 && !hold) check("contiguous", last_se - first_se, L - 1);
    @(negedge CK);
    #1 check("done_pulse", bus.done, 0);
    check("accepts_after", acc_cnt, NW);
    check("idle", bus.busy, 0);
    src_stop = 1;
    bus.s_valid = 0;
  endtask
  initial begin
    RST = 1;
    bus.start = 1;
    bus.s_valid = 0;
    bus.s_data = '0;
    bus.m_ready = 0;
    pre_en = 0;
    pre_v = '0;
    src_stop = 1;
    repeat (3) @(posedge CK);
    #1 check("reset_outs", outs, 0);
    bus.start = 0;
    RST = 0;
    repeat (2) @(posedge CK);
    #1 check("start_in_reset", bus.busy, 0);
    load(0, 0, 0, 0, 10'h3A5);
    check("rb0", got_rb.size() > 0 ? got_rb[0] : 4'hx, 4'h5);
    check("rb1", got_rb.size() > 1 ? got_rb[1] : 4'hx, 4'hA);
    check("rb2", got_rb.size() > 2 ? got_rb[2] : 4'hx, 4'h3);
    check("chain_lit_fast", chain, 10'h16B);
    load(0, 1, 0, 0, 10'h0F0);
    load(5, 0, 0, 0, 10'h155);
    check("chain_lit_starve", chain, 10'h16B);
    load(0, 0, 0, 6, 10'h2C3);
    load(0, 0, 1, 0, 10'h2C3);
    check("restart_rb0", got_rb.size() > 0 ? got_rb[0] : 4'hx, 4'h3);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
